// File: rtl/uart_pkg.sv
// Shared types for the framed UART receiver: FSM state encoding and parity_mode codes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  function automatic logic parity_used(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every CLK_FREQ/(BAUD*OVERSAMPLING) clocks (rounded).
module baud_tick_gen #(
  parameter int CLK_FREQ     = 12000000,
  parameter int BAUD         = 115200,
  parameter int OVERSAMPLING = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  output logic tick
);

  localparam int RATE    = BAUD * OVERSAMPLING;
  localparam int DIV_RAW = (CLK_FREQ + RATE / 2) / RATE;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = $clog2(DIV + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (enable) begin
        if (cnt == CW'(DIV - 1)) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx_framed.sv
// Framed UART receiver with glitch filter, break/overrun detection and idle tracking.
// Define UART_RX_PARITY_EN to compile in the PARITY state and parity_err checking.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 12000000,
  parameter int BAUD         = 115200,
  parameter int OVERSAMPLING = 8,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx,
  input  logic [1:0]           parity_mode,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 rx_idle,
  output logic                 rx_eop
);

  localparam int OSW   = $clog2(OVERSAMPLING);
  localparam int BCW   = $clog2(DATA_BITS + 1);
  localparam int GAP_W = $clog2(4 * OVERSAMPLING) + 1;

  logic                 tick;
  logic [1:0]           sync;
  logic [1:0]           filt_cnt;
  logic [1:0]           filt_cnt_next;
  logic                 filt;
  logic                 filt_prev;
  rx_state_t            state;
  logic [OSW-1:0]       os_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           par_mode_q;
  logic                 all_low;
  logic                 ferr_q;
  logic [GAP_W-1:0]     gap;
  logic                 sample;
  logic                 stop_is_break;
  logic                 stop_ferr;

  baud_tick_gen #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .OVERSAMPLING(OVERSAMPLING)
  ) u_tick (
    .clk   (clk),
    .resetn(resetn),
    .enable(1'b1),
    .tick  (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic perr_q;
  logic perr_hold;
  assign parity_err = perr_hold;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
  assign parity_err = 1'b0;
`endif

  // Start bit is checked half a bit in; every later bit one full bit after the previous sample.
  assign sample = tick && (os_cnt == ((state == START) ? OSW'(OVERSAMPLING / 2 - 1)
                                                       : OSW'(OVERSAMPLING - 1)));
  assign stop_is_break = all_low & ~filt;
  assign stop_ferr     = ferr_q | ~filt;
  assign rx_idle       = gap[GAP_W-1];

  always_comb begin
    filt_cnt_next = filt_cnt;
    if (sync[1] && filt_cnt != 2'b11)
      filt_cnt_next = filt_cnt + 2'd1;
    else if (!sync[1] && filt_cnt != 2'b00)
      filt_cnt_next = filt_cnt - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync      <= 2'b11;
      filt_cnt  <= 2'b11;
      filt      <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      sync      <= {sync[0], rx};
      filt_prev <= filt;
      if (tick) begin
        filt_cnt <= filt_cnt_next;
        if (filt_cnt_next == 2'b11)
          filt <= 1'b1;
        else if (filt_cnt_next == 2'b00)
          filt <= 1'b0;
      end
    end
  end

  // A falling filtered edge starts a frame, so a line left low by a bad stop bit cannot retrigger.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_mode_q <= PAR_NONE;
      all_low    <= 1'b0;
      ferr_q     <= 1'b0;
      gap        <= '1;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
      rx_eop     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
      perr_hold  <= 1'b0;
`endif
    end else begin
      overrun   <= 1'b0;
      break_det <= 1'b0;
      rx_eop    <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;
      if (tick)
        os_cnt <= sample ? '0 : os_cnt + 1'b1;

      if (state == IDLE) begin
        if (tick && !(&gap)) begin
          gap <= gap + 1'b1;
          if (gap == {1'b0, {(GAP_W-1){1'b1}}})
            rx_eop <= 1'b1;
        end
      end else begin
        gap <= '0;
      end

      case (state)
        IDLE: begin
          if (filt_prev && !filt) begin
            state  <= START;
            os_cnt <= '0;
`ifdef UART_RX_PARITY_EN
            par_mode_q <= parity_mode;
`else
            par_mode_q <= PAR_NONE;
`endif
          end
        end
        START: begin
          if (sample) begin
            if (!filt) begin
              state   <= DATA;
              bit_cnt <= '0;
              all_low <= 1'b1;
              ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              perr_q  <= 1'b0;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (sample) begin
            shreg   <= {filt, shreg[DATA_BITS-1:1]};
            all_low <= all_low & ~filt;
            if (bit_cnt == BCW'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= parity_used(par_mode_q) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample) begin
            perr_q  <= filt ^ (^shreg) ^ (par_mode_q == PAR_ODD);
            all_low <= all_low & ~filt;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (sample) begin
            if (bit_cnt == BCW'(STOP_BITS - 1)) begin
              if (stop_is_break) begin
                break_det <= 1'b1;
                state     <= WAIT_HIGH;
              end else begin
                state <= IDLE;
                if (!rx_valid || rx_ready) begin
                  rx_valid  <= 1'b1;
                  rx_data   <= shreg;
                  frame_err <= stop_ferr;
`ifdef UART_RX_PARITY_EN
                  perr_hold <= perr_q;
`endif
                end else begin
                  overrun <= 1'b1;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              ferr_q  <= stop_ferr;
              all_low <= stop_is_break;
            end
          end
        end
        WAIT_HIGH: begin
          if (filt)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
